// File: rtl/idecoder_seq.sv
// idecoder_seq: instruction register with decoded immediate/opcode fields, plus a
// handshaked sequencer that issues the register-file operand steps of each instruction.
module idecoder_seq #(
    parameter int DATA_W        = 16,
    parameter int RF_READ_PORTS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [15:0]       ir,
    output logic [2:0]        opcode,
    output logic [1:0]        ALU_op,
    output logic [1:0]        shift_op,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic              step_valid,
    input  logic              step_ready,
    output logic              rd_en,
    output logic              wr_en,
    output logic [1:0]        reg_sel,
    output logic [2:0]        r_addr,
    output logic [2:0]        w_addr,
    output logic [2:0]        r_addr_b,
    output logic              last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam bit DUAL = (RF_READ_PORTS == 2);

    state_t      state_q, state_d, next_step;
    logic [15:0] ir_q, ir_d;
    logic        retire;
    logic        arith;
    logic        is_cmp;
    logic        mov_imm;

    // First step is chosen from the word being loaded, not from the register.
    function automatic state_t first_step(input logic [2:0] op, input logic [1:0] alu);
        state_t s;
        s = IDLE;
        if (op == 3'b101)
            s = READ_A;
        else if (op == 3'b110 && alu == 2'b00)
            s = READ_A;
        else if (op == 3'b110 && alu == 2'b10)
            s = WRITE;
        return s;
    endfunction

    function automatic state_t after_step(input state_t st, input logic two_src, input logic cmp);
        state_t s;
        s = IDLE;
        case (st)
            READ_A: begin
                if (!two_src)
                    s = WRITE;
                else if (!DUAL)
                    s = READ_B;
                else if (!cmp)
                    s = WRITE;
            end
            READ_B:  if (!cmp) s = WRITE;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    assign arith   = (ir_q[15:13] == 3'b101) && (ir_q[12:11] != 2'b11);
    assign is_cmp  = (ir_q[15:13] == 3'b101) && (ir_q[12:11] == 2'b01);
    assign mov_imm = (ir_q[15:13] == 3'b110) && (ir_q[12:11] == 2'b10);

    assign opcode   = ir_q[15:13];
    assign ALU_op   = ir_q[12:11];
    assign shift_op = ir_q[4:3];
    assign sximm5   = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
    assign sximm8   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign busy     = (state_q != IDLE);

    always_comb begin
        next_step  = after_step(state_q, arith, is_cmp);
        step_valid = (state_q != IDLE);
        last       = step_valid && (next_step == IDLE);
        retire     = step_valid && step_ready;
        ir_ready   = !rst && (!step_valid || (retire && last));
        ir_d       = ir_q;
        state_d    = state_q;
        if (ir_valid && ir_ready) begin
            ir_d    = ir;
            state_d = first_step(ir[15:13], ir[12:11]);
        end else if (retire) begin
            state_d = last ? IDLE : next_step;
        end
    end

    always_comb begin
        rd_en   = (state_q == READ_A) || (state_q == READ_B);
        wr_en   = (state_q == WRITE);
        reg_sel = 2'b00;
        case (state_q)
            READ_A:  reg_sel = arith ? 2'b10 : 2'b00;
            WRITE:   reg_sel = mov_imm ? 2'b10 : 2'b01;
            default: reg_sel = 2'b00;
        endcase
        r_addr = ir_q[2:0];
        case (reg_sel)
            2'b10:   r_addr = ir_q[10:8];
            2'b01:   r_addr = ir_q[7:5];
            default: r_addr = ir_q[2:0];
        endcase
        w_addr   = r_addr;
        // With two read ports, Rm rides alongside Rn on the single read step.
        r_addr_b = (DUAL && state_q == READ_A && arith) ? ir_q[2:0] : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_idecoder_seq.sv
// Self-checking bench for idecoder_seq: one instance with a single read port,
// one with two read ports; expected operand steps flow through a scoreboard queue.
module tb_idecoder_seq;

    localparam logic [15:0] I_ADD  = 16'b101_00_001_010_00_011;
    localparam logic [15:0] I_MOVI = 16'b110_10_010_11111111;
    localparam logic [15:0] I_MVN  = 16'b101_11_000_100_00_110;
    localparam logic [15:0] I_CMP  = 16'b101_01_101_010_01_010;

    logic        clk, rst;
    logic        ir_valid, ir_ready, step_valid, step_ready;
    logic [15:0] ir;
    logic [2:0]  opcode, r_addr, w_addr, r_addr_b;
    logic [1:0]  ALU_op, shift_op, reg_sel;
    logic [15:0] sximm5, sximm8;
    logic        rd_en, wr_en, last, busy;

    logic        ir_valid2, ir_ready2, step_valid2, step_ready2;
    logic [15:0] ir2;
    logic [2:0]  opcode2, r_addr2, w_addr2, r_addr_b2;
    logic [1:0]  ALU_op2, shift_op2, reg_sel2;
    logic [15:0] sximm5_2, sximm8_2;
    logic        rd_en2, wr_en2, last2, busy2;

    int          vectors = 0;
    int          miscompares = 0;
    logic [13:0] sbq[$];
    logic [13:0] mon_got, mon_exp;

    idecoder_seq #(.DATA_W(16), .RF_READ_PORTS(1)) dut (
        .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
        .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op),
        .sximm5(sximm5), .sximm8(sximm8),
        .step_valid(step_valid), .step_ready(step_ready), .rd_en(rd_en), .wr_en(wr_en),
        .reg_sel(reg_sel), .r_addr(r_addr), .w_addr(w_addr), .r_addr_b(r_addr_b),
        .last(last), .busy(busy)
    );

    idecoder_seq #(.DATA_W(16), .RF_READ_PORTS(2)) dut2 (
        .clk(clk), .rst(rst), .ir_valid(ir_valid2), .ir_ready(ir_ready2), .ir(ir2),
        .opcode(opcode2), .ALU_op(ALU_op2), .shift_op(shift_op2),
        .sximm5(sximm5_2), .sximm8(sximm8_2),
        .step_valid(step_valid2), .step_ready(step_ready2), .rd_en(rd_en2), .wr_en(wr_en2),
        .reg_sel(reg_sel2), .r_addr(r_addr2), .w_addr(w_addr2), .r_addr_b(r_addr_b2),
        .last(last2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] stp(input logic rd, input logic wr, input logic [1:0] sel,
                                        input logic [2:0] a, input logic [2:0] b, input logic lst);
        return {rd, wr, sel, a, a, b, lst};
    endfunction

    // Every retired step of the single-port instance is matched against the queue.
    always @(negedge clk) begin
        if (step_valid && step_ready) begin
            mon_got = {rd_en, wr_en, reg_sel, r_addr, w_addr, r_addr_b, last};
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL step_unexpected: got %h, no step expected", mon_got);
            end else begin
                mon_exp = sbq.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL step: got %h want %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ir = I_ADD; ir_valid = 1'b1; step_ready = 1'b0;
        @(posedge clk); #1 ir_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_load: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({ir_ready, opcode, ALU_op, shift_op, sximm5, sximm8, step_valid, rd_en, wr_en,
             reg_sel, r_addr, w_addr, r_addr_b, last, busy} !== 56'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {ir_ready, opcode, ALU_op, shift_op, sximm5,
                     sximm8, step_valid, rd_en, wr_en, reg_sel, r_addr, w_addr, r_addr_b, last, busy});
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ir_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL idle_after_reset: got %b want 10", {ir_ready, busy}); end
        @(posedge clk); #1;
        sbq.push_back(stp(1'b0, 1'b1, 2'b10, 3'b010, 3'b000, 1'b1));
        ir = I_MOVI; ir_valid = 1'b1; step_ready = 1'b1;
        @(posedge clk); #1 ir_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({step_valid, opcode, sximm8} !== {1'b1, 3'b110, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL movi_fields: got %h want %h", {step_valid, opcode, sximm8}, {1'b1, 3'b110, 16'hFFFF});
        end
        @(negedge clk);
        vectors++;
        if ({step_valid, busy} !== 2'b00 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL movi_done: got valid/busy %b pending %0d want 00 and 0", {step_valid, busy}, sbq.size());
        end
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        sbq.push_back(stp(1'b1, 1'b0, 2'b10, 3'b001, 3'b000, 1'b0));
        sbq.push_back(stp(1'b1, 1'b0, 2'b00, 3'b011, 3'b000, 1'b0));
        sbq.push_back(stp(1'b0, 1'b1, 2'b01, 3'b010, 3'b000, 1'b1));
        ir = I_ADD; ir_valid = 1'b1; step_ready = 1'b1;
        @(posedge clk); #1 ir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({step_valid, ALU_op, shift_op} !== 5'b1_00_00) begin
                miscompares++;
                $display("FAIL add_cycle%0d: got %b want 10000", i, {step_valid, ALU_op, shift_op});
            end
        end
        @(negedge clk);
        vectors++;
        if ({step_valid, busy} !== 2'b00 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL add_done: got valid/busy %b pending %0d want 00 and 0", {step_valid, busy}, sbq.size());
        end
    endtask

    task automatic test_cmp_dual();
        @(posedge clk); #1;
        ir2 = I_CMP; ir_valid2 = 1'b1; step_ready2 = 1'b1;
        @(posedge clk); #1 ir_valid2 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({step_valid2, rd_en2, wr_en2, reg_sel2, r_addr2, r_addr_b2, last2} !== {3'b110, 2'b10, 3'b101, 3'b010, 1'b1}) begin
            miscompares++;
            $display("FAIL cmp2_step: got %b want %b", {step_valid2, rd_en2, wr_en2, reg_sel2, r_addr2, r_addr_b2, last2},
                     {3'b110, 2'b10, 3'b101, 3'b010, 1'b1});
        end
        vectors++;
        if (sximm5_2 !== 16'h000A) begin miscompares++; $display("FAIL cmp2_sximm5: got %h want 000a", sximm5_2); end
        @(negedge clk);
        vectors++;
        if ({step_valid2, wr_en2, busy2} !== 3'b000) begin
            miscompares++;
            $display("FAIL cmp2_no_write: got %b want 000", {step_valid2, wr_en2, busy2});
        end
        @(posedge clk); #1;
        ir2 = I_ADD; ir_valid2 = 1'b1;
        @(posedge clk); #1 ir_valid2 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rd_en2, reg_sel2, r_addr2, r_addr_b2, last2} !== {1'b1, 2'b10, 3'b001, 3'b011, 1'b0}) begin
            miscompares++;
            $display("FAIL add2_read: got %b want %b", {rd_en2, reg_sel2, r_addr2, r_addr_b2, last2},
                     {1'b1, 2'b10, 3'b001, 3'b011, 1'b0});
        end
        @(negedge clk);
        vectors++;
        if ({wr_en2, reg_sel2, w_addr2, r_addr_b2, last2} !== {1'b1, 2'b01, 3'b010, 3'b000, 1'b1}) begin
            miscompares++;
            $display("FAIL add2_write: got %b want %b", {wr_en2, reg_sel2, w_addr2, r_addr_b2, last2},
                     {1'b1, 2'b01, 3'b010, 3'b000, 1'b1});
        end
        @(negedge clk);
        vectors++;
        if (busy2 !== 1'b0) begin miscompares++; $display("FAIL add2_done: got busy %b want 0", busy2); end
    endtask

    task automatic test_stall_back_to_back();
        @(posedge clk); #1;
        sbq.push_back(stp(1'b1, 1'b0, 2'b00, 3'b110, 3'b000, 1'b0));
        sbq.push_back(stp(1'b0, 1'b1, 2'b01, 3'b100, 3'b000, 1'b1));
        ir = I_MVN; ir_valid = 1'b1; step_ready = 1'b0;
        @(posedge clk); #1 ir_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({step_valid, rd_en, reg_sel, r_addr} !== {2'b11, 2'b00, 3'b110}) begin
                miscompares++;
                $display("FAIL stall_read%0d: got %b want 1100110", k, {step_valid, rd_en, reg_sel, r_addr});
            end
            if (k == 2) begin
                @(posedge clk); #1 step_ready = 1'b1;
            end
        end
        @(posedge clk); #1;
        sbq.push_back(stp(1'b1, 1'b0, 2'b10, 3'b001, 3'b000, 1'b0));
        sbq.push_back(stp(1'b1, 1'b0, 2'b00, 3'b011, 3'b000, 1'b0));
        sbq.push_back(stp(1'b0, 1'b1, 2'b01, 3'b010, 3'b000, 1'b1));
        ir = I_ADD; ir_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wr_en, w_addr, last, ir_ready} !== {1'b1, 3'b100, 2'b11}) begin
            miscompares++;
            $display("FAIL mvn_write: got %b want 110011", {wr_en, w_addr, last, ir_ready});
        end
        @(posedge clk); #1 ir_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rd_en, reg_sel, r_addr, busy} !== {1'b1, 2'b10, 3'b001, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_read_a: got %b want 1100011", {rd_en, reg_sel, r_addr, busy});
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_done: got busy %b pending %0d want 0 and 0", busy, sbq.size());
        end
    endtask

    task automatic test_zero_step();
        @(posedge clk); #1;
        ir = 16'h0000; ir_valid = 1'b1; step_ready = 1'b1;
        @(posedge clk); #1 ir = 16'hFFFF;
        @(negedge clk);
        vectors++;
        if ({busy, step_valid, ir_ready, opcode, ALU_op, shift_op, sximm5, sximm8} !== {3'b001, 7'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL zero_0000: got %h want %h", {busy, step_valid, ir_ready, opcode, ALU_op, shift_op, sximm5, sximm8},
                     {3'b001, 7'd0, 32'd0});
        end
        @(posedge clk); #1 ir_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, step_valid, ir_ready, opcode, ALU_op, shift_op, sximm5, sximm8} !== {3'b001, 7'h7F, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL zero_ffff: got %h want %h", {busy, step_valid, ir_ready, opcode, ALU_op, shift_op, sximm5, sximm8},
                     {3'b001, 7'h7F, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        sbq.push_back(stp(1'b1, 1'b0, 2'b10, 3'b001, 3'b000, 1'b0));
        ir = I_ADD; ir_valid = 1'b1; step_ready = 1'b1;
        @(posedge clk); #1 ir_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({rd_en, reg_sel, r_addr} !== {1'b1, 2'b00, 3'b011}) begin
            miscompares++;
            $display("FAIL mid_read_b: got %b want 100011", {rd_en, reg_sel, r_addr});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({step_valid, busy, ir_ready, wr_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset: got %b want 0000", {step_valid, busy, ir_ready, wr_en});
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, ir_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_release: got %b want 01", {busy, ir_ready});
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (sbq.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_no_write: pending %0d busy %b want 0 and 0", sbq.size(), busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ir_valid = 1'b0; ir = '0; step_ready = 1'b0;
        ir_valid2 = 1'b0; ir2 = '0; step_ready2 = 1'b0;
        test_reset();
        test_add();
        test_cmp_dual();
        test_stall_back_to_back();
        test_zero_step();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
